key_debounce_toggle: RTL and testbench

//  Conditions one raw board push-button into clean single-clock events and a toggle level.

---
 rtl/key_debounce_toggle_if.sv | 45 ++++
 rtl/key_debounce_toggle.sv | 177 +++++++++++++++++
 tb/tb_key_debounce_toggle.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/key_debounce_toggle_if.sv
// -----------------------------------------------------------------------------
// key_debounce_toggle_if
//
// Purpose:
//   Bundles the push-button conditioning signals exchanged between the
//   board-side world (raw key, consumers of the clean events) and the
//   key_debounce_toggle block. The clock and reset stay plain ports on the
//   block itself.
//
// Signals:
//   key_in         raw, asynchronous, bouncing button level
//   key_level      debounced pressed level (1 = pressed)
//   press_pulse    one clk_in cycle high on an accepted press
//   release_pulse  one clk_in cycle high on an accepted release
//   toggle_out     flips on every accepted press (drives divider frq_switch)
//
// Modports:
//   master  board / consumer side: drives key_in, observes the outputs
//   slave   debouncer side: samples key_in, drives the outputs
// -----------------------------------------------------------------------------
interface key_debounce_toggle_if;

  logic key_in;
  logic key_level;
  logic press_pulse;
  logic release_pulse;
  logic toggle_out;

  modport master (
    output key_in,
    input  key_level,
    input  press_pulse,
    input  release_pulse,
    input  toggle_out
  );

  modport slave (
    input  key_in,
    output key_level,
    output press_pulse,
    output release_pulse,
    output toggle_out
  );

endinterface : key_debounce_toggle_if

// File: rtl/key_debounce_toggle.sv
// -----------------------------------------------------------------------------
// key_debounce_toggle
//
// Purpose:
//   Turns one raw board push-button into a clean debounced level, single-cycle
//   press/release events and a toggle level. toggle_out feeds the clock
//   divider's frq_switch input (fast/slow CPU clock select); the pulses can be
//   used as interrupt-request sources. Runs on the raw board clock clk_in.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable synchronised samples needed to accept a
//                    level change (legal range >= 2)
//   KEY_ACTIVE_LOW   1: key_in low means pressed; 0: key_in high means pressed
//   TOGGLE_INIT      reset value of toggle_out
//
// Ports:
//   clk_in   system clock, all logic on posedge
//   rst_n    asynchronous, active-low reset
//   key_if   slave modport of key_debounce_toggle_if
//            (key_in in; key_level, press_pulse, release_pulse, toggle_out out)
//
// Timing:
//   A clean press first sampled by the synchroniser at edge E is seen by the
//   FSM at E+2; key_level, press_pulse and toggle_out change at edge
//   E+DEBOUNCE_CYCLES+1. Release is symmetric. Every output is a flop.
// -----------------------------------------------------------------------------
module key_debounce_toggle #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b0,
  parameter bit          TOGGLE_INIT     = 1'b0
) (
  input  logic                  clk_in,
  input  logic                  rst_n,
  key_debounce_toggle_if.slave  key_if
);

  // Counter is one bit wider than strictly needed and saturates, so a stuck
  // counter can never wrap back into a value that looks like a fresh count.
  localparam int unsigned          CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CNT_W-1:0]     CNT_MAX  = '1;
  // The sample that enters a debounce state already counts as the first one,
  // and the counter is cleared on that entry, so the final accepted sample
  // arrives while the counter holds DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 2);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DB_PRESS = 2'd1,
    HELD     = 2'd2,
    DB_REL   = 2'd3
  } state_e;

  // ---------------------------------------------------------------------------
  // Input polarity normalisation: from here on 1 always means "pressed".
  // ---------------------------------------------------------------------------
  logic key_norm;
  assign key_norm = key_if.key_in ^ KEY_ACTIVE_LOW;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic             sync1_q,         sync1_d;
  logic             key_s_q,         key_s_d;
  state_e           state_q,         state_d;
  logic [CNT_W-1:0] cnt_q,           cnt_d;
  logic             key_level_q,     key_level_d;
  logic             press_pulse_q,   press_pulse_d;
  logic             release_pulse_q, release_pulse_d;
  logic             toggle_q,        toggle_d;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    sync1_d         = key_norm;
    key_s_d         = sync1_q;
    state_d         = state_q;
    cnt_d           = cnt_q;
    key_level_d     = key_level_q;
    press_pulse_d   = 1'b0;
    release_pulse_d = 1'b0;
    toggle_d        = toggle_q;

    unique case (state_q)
      IDLE: begin
        if (key_s_q) begin
          state_d = DB_PRESS;
          cnt_d   = '0;
        end
      end

      DB_PRESS: begin
        if (!key_s_q) begin
          // Glitch shorter than the debounce window: drop it silently.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d       = HELD;
          cnt_d         = '0;
          key_level_d   = 1'b1;
          press_pulse_d = 1'b1;
          toggle_d      = ~toggle_q;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end

      HELD: begin
        // Holding the key forever stays here: no auto-repeat.
        if (!key_s_q) begin
          state_d = DB_REL;
          cnt_d   = '0;
        end
      end

      DB_REL: begin
        if (key_s_q) begin
          // Release bounce: still pressed, no event.
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q >= CNT_LAST) begin
          state_d         = IDLE;
          cnt_d           = '0;
          key_level_d     = 1'b0;
          release_pulse_d = 1'b1;
        end else begin
          cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the synchroniser resets to "not pressed" rather than to the live
      // key, so a key held through reset is debounced as a brand-new press.
      sync1_q         <= 1'b0;
      key_s_q         <= 1'b0;
      state_q         <= IDLE;
      cnt_q           <= '0;
      key_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      toggle_q        <= TOGGLE_INIT;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values;
      // blocking here would collapse the 2-FF synchroniser into one stage.
      sync1_q         <= sync1_d;
      key_s_q         <= key_s_d;
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      key_level_q     <= key_level_d;
      press_pulse_q   <= press_pulse_d;
      release_pulse_q <= release_pulse_d;
      toggle_q        <= toggle_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (straight from flops)
  // ---------------------------------------------------------------------------
  assign key_if.key_level     = key_level_q;
  assign key_if.press_pulse   = press_pulse_q;
  assign key_if.release_pulse = release_pulse_q;
  assign key_if.toggle_out    = toggle_q;

endmodule : key_debounce_toggle

// File: tb/tb_key_debounce_toggle.sv
// -----------------------------------------------------------------------------
// tb_key_debounce_toggle
//
// Two instances run side by side on the same stimulus: one active-high key,
// one active-low key driven with the inverted level. Both must produce the
// same outputs. Outputs are compared as {key_level, press_pulse,
// release_pulse, toggle_out}.
//
// Expected values come from a directed vector table, hand-written corner-case
// sequences, and a run-length reference model: the model delays the key by
// the two synchroniser samples and flips its level once the run of samples
// disagreeing with the current level reaches DEBOUNCE_CYCLES.
// -----------------------------------------------------------------------------
module tb_key_debounce_toggle;

  localparam int DB = 8;

  logic clk_in = 1'b0;
  logic rst_n;

  always #5 clk_in = ~clk_in;

  key_debounce_toggle_if hi_if ();
  key_debounce_toggle_if lo_if ();

  key_debounce_toggle #(
    .DEBOUNCE_CYCLES (DB),
    .KEY_ACTIVE_LOW  (1'b0),
    .TOGGLE_INIT     (1'b0)
  ) u_dut_hi (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .key_if (hi_if)
  );

  key_debounce_toggle #(
    .DEBOUNCE_CYCLES (DB),
    .KEY_ACTIVE_LOW  (1'b1),
    .TOGGLE_INIT     (1'b0)
  ) u_dut_lo (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .key_if (lo_if)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b, expected %b (level,press,release,toggle)",
               name, $time, act, exp);
    end
  endtask

  function automatic logic [3:0] out_hi();
    return {hi_if.key_level, hi_if.press_pulse, hi_if.release_pulse, hi_if.toggle_out};
  endfunction

  function automatic logic [3:0] out_lo();
    return {lo_if.key_level, lo_if.press_pulse, lo_if.release_pulse, lo_if.toggle_out};
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model (pressed = 1)
  // ---------------------------------------------------------------------------
  bit   m_pipe[$];
  int   m_run;
  logic m_level, m_press, m_rel, m_toggle;

  task automatic model_reset();
    m_pipe   = '{1'b0, 1'b0};
    m_run    = 0;
    m_level  = 1'b0;
    m_press  = 1'b0;
    m_rel    = 1'b0;
    m_toggle = 1'b0;
  endtask

  task automatic model_edge(input bit pressed);
    bit ks;
    m_pipe.push_back(pressed);
    ks      = m_pipe.pop_front();
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (ks != m_level) begin
      m_run++;
      if (m_run == DB) begin
        m_level = ks;
        m_run   = 0;
        if (ks) begin
          m_press  = 1'b1;
          m_toggle = ~m_toggle;
        end else begin
          m_rel = 1'b1;
        end
      end
    end else begin
      m_run = 0;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers (entered and left at a negedge of clk_in)
  // ---------------------------------------------------------------------------
  task automatic step(input logic pressed, input bit directed,
                      input logic [3:0] exp, input string name);
    logic [3:0] want;
    hi_if.key_in = pressed;
    lo_if.key_in = ~pressed;
    model_edge(pressed);
    @(posedge clk_in);
    @(negedge clk_in);
    want = directed ? exp : {m_level, m_press, m_rel, m_toggle};
    check({name, "_hi"}, out_hi(), want);
    check({name, "_lo"}, out_lo(), want);
  endtask

  // Reset asserted in the middle of the low clock phase, checked before the
  // next posedge so the outputs can only have changed asynchronously.
  task automatic reset_async(input string name);
    #2 rst_n = 1'b0;
    #1;
    check({name, "_async_hi"}, out_hi(), 4'b0000);
    check({name, "_async_lo"}, out_lo(), 4'b0000);
    model_reset();
    repeat (2) @(negedge clk_in);
    check({name, "_held_hi"}, out_hi(), 4'b0000);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic       key;
    logic [3:0] exp;
  } vec_t;

  vec_t vecs[23];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    bit key_r;
    int len;

    // Press: 9 quiet edges, pulse on the 10th (edge E+9), then held.
    for (int j = 0; j < 12; j++)
      vecs[j] = '{1'b1, (j < 9) ? 4'b0000 : (j == 9) ? 4'b1101 : 4'b1001};
    // Release: symmetric, toggle stays 1.
    for (int j = 0; j < 11; j++)
      vecs[12 + j] = '{1'b0, (j < 9) ? 4'b1001 : (j == 9) ? 4'b0011 : 4'b0001};

    // 1. Reset with key idle, then 20 idle cycles.
    rst_n        = 1'b1;
    hi_if.key_in = 1'b0;
    lo_if.key_in = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_hi", out_hi(), 4'b0000);
    check("reset_lo", out_lo(), 4'b0000);
    model_reset();
    repeat (2) @(negedge clk_in);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'b0000, "idle");

    // 2. Clean press and release from the vector table.
    foreach (vecs[i]) step(vecs[i].key, 1'b1, vecs[i].exp, $sformatf("tbl%0d", i));

    // 4. Second full press/release: toggle returns to 0.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 4'b0000, "press2");
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'b0000, "rel2");
    check("two_cycles_end_hi", out_hi(), 4'b0000);

    // 3. Bounce 1,0,1,0 every 3 cycles, then steady press.
    for (int b = 0; b < 4; b++)
      for (int i = 0; i < 3; i++) step((b % 2) == 0, 1'b1, 4'b0000, "bounce");
    for (int j = 0; j < 12; j++)
      step(1'b1, 1'b1, (j < 9) ? 4'b0000 : (j == 9) ? 4'b1101 : 4'b1001, "after_bounce");

    // 5. Release, start a new press, reset mid-debounce with key still held.
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 4'b0000, "rel3");
    for (int i = 0; i < 7; i++)  step(1'b1, 1'b0, 4'b0000, "press_mid");
    reset_async("rst_mid_db");
    for (int j = 0; j < 11; j++)
      step(1'b1, 1'b1, (j < 9) ? 4'b0000 : (j == 9) ? 4'b1101 : 4'b1001, "held_thru_rst");

    // Reset while HELD with toggle=1: everything drops at once.
    hi_if.key_in = 1'b0;
    lo_if.key_in = 1'b1;
    reset_async("rst_held");
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'b0000, "post_rst_idle");

    // Randomised bursts against the reference model, with occasional resets.
    for (int burst = 0; burst < 150; burst++) begin
      key_r = ($urandom_range(0, 1) == 1);
      len   = int'($urandom_range(1, 14));
      for (int i = 0; i < len; i++) step(key_r, 1'b0, 4'b0000, "rand");
      if ($urandom_range(0, 24) == 0) reset_async("rand_rst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_key_debounce_toggle
